// File: rtl/char_stream_sequencer.sv
// char_stream_sequencer: pulls characters one at a time from a character reader,
// buffers each one and hands it downstream over valid/ready until the reader
// reports end of stream or the per-run character limit is reached.
module char_stream_sequencer #(
    parameter int unsigned CHAR_WIDTH  = 8,
    parameter int unsigned MAX_CHARS   = 1024,
    parameter int unsigned COUNT_WIDTH = 11
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   rd_enable,
    input  logic [CHAR_WIDTH-1:0]  rd_char,
    input  logic                   rd_finished,
    output logic [CHAR_WIDTH-1:0]  out_char,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] char_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_CHARS);

    logic [2:0]             state_q,    state_d;
    logic [CHAR_WIDTH-1:0]  char_q,     char_d;
    logic [COUNT_WIDTH-1:0] count_q,    count_d;
    logic                   overflow_q, overflow_d;
    logic                   rd_en_q,    rd_en_d;
    logic                   valid_q,    valid_d;
    logic                   busy_q,     busy_d;
    logic                   done_q,     done_d;

    // Next-state logic; output registers are derived from the next state so
    // every output is a flop that reflects the state it belongs to.
    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_ISSUE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // A finished reader leaves rd_char stale, so no beat is produced.
                if (rd_finished) begin
                    state_d = S_DONE;
                end else begin
                    char_d  = rd_char;
                    state_d = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                    if (count_d == MAX_COUNT) begin
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_ISSUE);
        valid_d = (state_d == S_PRESENT);
        busy_d  = (state_d == S_ISSUE) || (state_d == S_CAPTURE) || (state_d == S_PRESENT);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            char_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_en_q    <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_q     <= char_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_en_q    <= rd_en_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rd_enable  = rd_en_q;
    assign out_char   = char_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign char_count = count_q;

endmodule

// File: doc/char_stream_sequencer.md
Name: char_stream_sequencer

Overview:
- Drives the character reader's `state_enable` request line. Pulls one character per request, buffers it, and presents it downstream over a valid/ready handshake until the reader signals end of stream.
- Sits between the reader (`dummy_reader` or any later file/memory reader with the same interface) and the HTML tokenizer/parser.
- Also counts delivered characters and enforces a maximum document length.

Parameters:
- CHAR_WIDTH, 8, bits per character; must equal the reader's char width.
- MAX_CHARS, 1024, maximum characters delivered per run before overflow stop; must be ≥1.
- COUNT_WIDTH, 11, width of `char_count`; must hold MAX_CHARS.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run; ignored unless in IDLE or DONE.
- rd_enable  output  1  to reader `state_enable`; one request per high pulse.
- rd_char  input  CHAR_WIDTH  reader `char`.
- rd_finished  input  1  reader `has_finished`.
- out_char  output  CHAR_WIDTH  character presented downstream.
- out_valid  output  1  `out_char` is valid.
- out_ready  input  1  downstream accepts when `out_valid && out_ready`.
- busy  output  1  high in any state except IDLE and DONE.
- done  output  1  high in DONE.
- overflow  output  1  run stopped because MAX_CHARS was reached; sticky until next start or reset.
- char_count  output  COUNT_WIDTH  characters accepted downstream this run.

Behaviour:
- Reader contract:
  - The reader samples `state_enable` high at a posedge.
  - At that same edge it updates either `char` or `has_finished`.
  - It re-arms only after it sees `state_enable` low for at least one edge.
- The sequencer never holds `rd_enable` high for two consecutive cycles.
- Reset (synchronous): state=IDLE; `rd_enable`=0, `out_valid`=0, `out_char`=0, `busy`=0, `done`=0, `overflow`=0, `char_count`=0. Reset overrides every other input in the same cycle, including reset arriving mid-run.
- States:
  - IDLE:
    - All outputs are held at their reset values.
    - `start` → ISSUE; the same edge clears `char_count` and `overflow`.
  - ISSUE:
    - `rd_enable`=1 for exactly this cycle.
    - Next state is always CAPTURE.
  - CAPTURE:
    - `rd_enable`=0.
    - At the closing edge, if `rd_finished`=1 → DONE.
    - Otherwise register `rd_char` into `out_char` and go to PRESENT.
  - PRESENT:
    - `out_valid`=1; `out_char` is held stable.
    - On the edge where `out_ready`=1:
      - `char_count` increments.
      - If the new count equals MAX_CHARS, set `overflow`=1 and go to DONE.
      - Otherwise go to ISSUE.
    - With `out_ready`=0, stay in PRESENT indefinitely. No new request is issued while stalled.
  - DONE:
    - `done`=1 and `out_valid`=0; `char_count` is frozen.
    - `start` → ISSUE; the same edge clears `char_count` and `overflow`.
    - The reader is not reset by this block. Restarting against a finished reader yields an immediate DONE with count 0.
- Latency and throughput:
  - The ISSUE cycle is n.
  - `out_valid` rises at cycle n+2.
  - Peak throughput is 1 character per 3 cycles when `out_ready` is held high.
- `rd_finished` is sampled only in CAPTURE. A finished indication arriving with a stale `rd_char` produces no output beat.
- A character value of 0 (NUL) is passed through like any other character. Only `rd_finished` ends the stream.
- `char_count` never exceeds MAX_CHARS and never wraps.
- `start` while `busy`=1 is ignored; there is no restart mid-run.
- `busy` and `done` are never high together.

Test Plan:
- Basic stream: connect `dummy_reader`, reset, pulse `start`, hold `out_ready`=1.
  - The output beat sequence is "body><p color=7 size=2 >test</p></body>" (39 beats).
  - `done`=1 afterwards, `char_count`=39, `overflow`=0.
  - The first `out_valid` appears exactly 2 cycles after the first `rd_enable`.
- Request spacing: same setup. Check that `rd_enable` is never high on consecutive cycles and that there are exactly 40 `rd_enable` pulses in the run.
- Backpressure: drop `out_ready` for 5 cycles on beat 3 ("d").
  - `out_char` holds "d" with `out_valid`=1 throughout the stall.
  - No `rd_enable` is issued during the stall.
  - The final sequence and count are unchanged.
- Overflow: set MAX_CHARS=4 and run.
  - Beats are "b","o","d","y".
  - Then `done`=1, `overflow`=1, `char_count`=4, with no 5th `rd_enable` pulse.
- Reset mid-run: assert `reset` in PRESENT at beat 10.
  - The next cycle shows all outputs at reset values and state IDLE.
  - A `start` pulse during `busy` in another run is ignored, and the count is unaffected.
- Restart after done: pulse `start` in DONE against a finished reader.
  - `busy` goes high for 2 cycles, then `done`=1 again with `char_count`=0 and no `out_valid`.
